multicycle_control: RTL and testbench

Control unit for the multicycle RV32I core. It decodes the opcode, funct3, funct7 and Zero flag that the datapath returns. It drives every datapath select and write enable, one FSM state per clock. Together with the datapath it forms the complete CPU; this block holds all sequencing and the datapath holds no state machine.

---
 rtl/multicycle_control.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Control FSM for the multicycle RV32I core: sequences one datapath step per clock and
// drives every select, write enable and the ALU operation.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_code,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  output logic       adr_src,
  output logic       mem_write,
  output logic       IR_write,
  output logic       reg_write,
  output logic       PC_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       instr_done
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] EXECI    = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] JAL      = 4'd9;
  localparam logic [3:0] BEQ      = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [3:0] state_q, state_d;
  logic       pc_update, branch;
  logic [1:0] alu_op;

  // Only funct7[5] distinguishes sub from add.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    IR_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    instr_done  = 1'b0;
    pc_update   = 1'b0;
    branch      = 1'b0;
    alu_op      = 2'b00;
    imm_src     = 2'b00;
    alu_control = 3'b000;

    case (state_q)
      FETCH: begin
        IR_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
        state_d    = DECODE;
      end
      DECODE: begin
        // ALU forms old_PC + imm here so a branch target is waiting in ALU_out.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op_code)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_JAL:       state_d = JAL;
          OP_BEQ:       state_d = BEQ;
          default: begin
            state_d    = FETCH;
            instr_done = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op_code == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end
      BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase

    case (op_code)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase

    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (op_code[5] & funct7[5]) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b100:  alu_control = 3'b100;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase

    PC_write = pc_update | (branch & Zero);

    // Reset aborts whatever is in flight: nothing may be written this cycle.
    if (reset) begin
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      IR_write    = 1'b0;
      reg_write   = 1'b0;
      PC_write    = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      imm_src     = 2'b00;
      alu_control = 3'b000;
      instr_done  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expected per-cycle output vectors are queued with
// each instruction and compared against the DUT one clock at a time.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op_code;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       adr_src, mem_write, IR_write, reg_write, PC_write, instr_done;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;

  int errors = 0;
  int checks = 0;
  logic [18:0] sb_q[$];

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk         (clk),
    .reset       (reset),
    .op_code     (op_code),
    .funct3      (funct3),
    .funct7      (funct7),
    .Zero        (Zero),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .IR_write    (IR_write),
    .reg_write   (reg_write),
    .PC_write    (PC_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .instr_done  (instr_done)
  );

  // Order: adr mw irw rw pcw rs[2] a[2] b[2] imm[2] alu[3] done
  function automatic logic [18:0] mk(input logic adr, input logic mw, input logic irw,
                                     input logic rw, input logic pcw, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] imm, input logic [2:0] alu,
                                     input logic done);
    return {adr, mw, irw, rw, pcw, rs, a, b, imm, alu, done};
  endfunction

  // Fetch and decode outputs shared by every instruction.
  task automatic push_fetch_decode(input logic [1:0] imm, input logic illegal);
    sb_q.push_back(mk(0, 0, 1, 0, 1, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0));
    sb_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, illegal));
  endtask

  // Compare one cycle at the falling edge, then advance to just after the next rising edge.
  task automatic step(input string tag);
    logic [18:0] obs, exp;
    @(negedge clk);
    obs = {adr_src, mem_write, IR_write, reg_write, PC_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_control, instr_done};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed=%b", tag, obs);
    end else begin
      exp = sb_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic z);
    op_code = op;
    funct3  = f3;
    funct7  = f7;
    Zero    = z;
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step($sformatf("%s_c%0d", tag, i + 1));
  endtask

  initial begin
    reset = 1'b1;
    set_instr(7'b0110011, 3'b000, 7'b0100000, 1'b1);
    @(posedge clk);
    #1;

    // Reset held: everything zero even with live decode inputs
    for (int i = 0; i < 3; i++) sb_q.push_back('0);
    run("reset", 3);
    reset = 1'b0;

    // lw: 5 cycles
    set_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0);
    push_fetch_decode(2'b00, 0);
    sb_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
    sb_q.push_back(mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    sb_q.push_back(mk(0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1));
    run("lw", 5);

    // R-type sub
    set_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0);
    push_fetch_decode(2'b00, 0);
    sb_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0));
    sb_q.push_back(mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1));
    run("sub", 4);

    // R-type xor
    set_instr(7'b0110011, 3'b100, 7'b0000000, 1'b0);
    push_fetch_decode(2'b00, 0);
    sb_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b100, 0));
    sb_q.push_back(mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1));
    run("xor", 4);

    // addi with funct7[5] set must still add
    set_instr(7'b0010011, 3'b000, 7'b0100000, 1'b0);
    push_fetch_decode(2'b00, 0);
    sb_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
    sb_q.push_back(mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1));
    run("addi", 4);

    // slti, andi, ori
    set_instr(7'b0010011, 3'b010, 7'b0000000, 1'b0);
    push_fetch_decode(2'b00, 0);
    sb_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b101, 0));
    sb_q.push_back(mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1));
    run("slti", 4);
    set_instr(7'b0010011, 3'b111, 7'b0000000, 1'b0);
    push_fetch_decode(2'b00, 0);
    sb_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b010, 0));
    sb_q.push_back(mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1));
    run("andi", 4);
    set_instr(7'b0010011, 3'b110, 7'b0000000, 1'b0);
    push_fetch_decode(2'b00, 0);
    sb_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b011, 0));
    sb_q.push_back(mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1));
    run("ori", 4);

    // beq taken / not taken
    set_instr(7'b1100011, 3'b000, 7'b0000000, 1'b1);
    push_fetch_decode(2'b10, 0);
    sb_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1));
    run("beq_t", 3);
    set_instr(7'b1100011, 3'b000, 7'b0000000, 1'b0);
    push_fetch_decode(2'b10, 0);
    sb_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1));
    run("beq_nt", 3);

    // jal
    set_instr(7'b1101111, 3'b000, 7'b0000000, 1'b0);
    push_fetch_decode(2'b11, 0);
    sb_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0));
    sb_q.push_back(mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1));
    run("jal", 4);

    // sw
    set_instr(7'b0100011, 3'b010, 7'b0000000, 1'b0);
    push_fetch_decode(2'b01, 0);
    sb_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
    sb_q.push_back(mk(1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1));
    run("sw", 4);

    // Illegal opcode: nop in two cycles
    set_instr(7'b1111111, 3'b000, 7'b0000000, 1'b1);
    push_fetch_decode(2'b00, 1);
    run("illegal", 2);

    // sw aborted by reset in MEMWRITE, then a fresh fetch
    set_instr(7'b0100011, 3'b010, 7'b0000000, 1'b0);
    push_fetch_decode(2'b01, 0);
    sb_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
    run("sw_abort", 3);
    reset = 1'b1;
    sb_q.push_back('0);
    run("sw_abort_rst", 1);
    reset = 1'b0;
    push_fetch_decode(2'b01, 0);
    run("after_abort", 2);

    if (sb_q.size() != 0) begin
      errors++;
      $error("FAIL leftover observed=%0d expected=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
